mem_request_arbiter: RTL

//  Shares the single RAM port between the instruction fetch path and the data load/store path.

---
 rtl/mem_request_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_request_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data load/store.
// One RAM transaction at a time, bounded data bursts while a fetch waits, fault pulse on error/timeout.
module mem_request_arbiter #(
  parameter int unsigned MAX_DBURST = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction fetch side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data load/store side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;
  localparam logic [3:0] MaxBurst  = 4'(MAX_DBURST);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIAcc = 2'd1,
    StDAcc = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        fetch_starved;
  logic        data_req;
  logic        ram_done;
  logic        ram_abort;

  assign fetch_starved = iREN && (burst_q == MaxBurst);
  assign data_req      = dREN || dWEN;
  assign ram_done      = (ramstate == RamAccess);
  assign ram_abort     = (ramstate == RamError) || (tcnt_q == TimeoutCnt);

  // Read data is passed straight through; only the owner's wait strobe qualifies it.
  assign iload = ramload;
  assign dload = ramload;

  // RAM-facing outputs come directly from flops so they are glitch-free.
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    burst_d = burst_q;
    tcnt_d  = tcnt_q;
    iwait   = 1'b1;
    dwait   = 1'b1;
    fault   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tcnt_d = 8'd0;
        if (fetch_starved || (iREN && !data_req)) begin
          state_d = StIAcc;
          addr_d  = iaddr;
          store_d = 32'd0;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          burst_d = 4'd0;
        end else if (data_req) begin
          state_d = StDAcc;
          addr_d  = daddr;
          store_d = dstore;
          // A simultaneous read/write request is treated as a write.
          wen_d   = dWEN;
          ren_d   = !dWEN;
          if (!iREN) begin
            burst_d = 4'd0;
          end else if (burst_q != MaxBurst) begin
            burst_d = burst_q + 4'd1;
          end
        end
      end

      StIAcc, StDAcc: begin
        tcnt_d = tcnt_q + 8'd1;
        if (ram_done || ram_abort) begin
          if (ram_done) begin
            if (state_q == StIAcc) begin
              iwait = 1'b0;
            end else begin
              dwait = 1'b0;
            end
          end else begin
            // Requester still holds its request, so returning to IDLE retries it.
            fault = 1'b1;
          end
          state_d = StIdle;
          addr_d  = 32'd0;
          store_d = 32'd0;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        addr_d  = 32'd0;
        store_d = 32'd0;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      burst_q <= 4'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      burst_q <= burst_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
